// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : size encodings, FSM states and alignment check for the LSU
// Revision: 1.0
// ============================================================================
package lsu_pkg;

  localparam logic [1:0] c_SZ_B = 2'd0;
  localparam logic [1:0] c_SZ_H = 2'd1;
  localparam logic [1:0] c_SZ_W = 2'd2;
  localparam logic [1:0] c_SZ_D = 2'd3;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t c_ST_IDLE  = 2'd0;
  localparam lsu_state_t c_ST_ISSUE = 2'd1;
  localparam lsu_state_t c_ST_WAIT  = 2'd2;
  localparam lsu_state_t c_ST_DONE  = 2'd3;

  // Doubleword is only a legal size on a 64-bit datapath.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [2:0] addr_lo,
                                          input logic       is64);
    logic bad;
    case (size)
      c_SZ_B:  bad = 1'b0;
      c_SZ_H:  bad = addr_lo[0];
      c_SZ_W:  bad = |addr_lo[1:0];
      default: bad = ~is64 | (|addr_lo);
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : byte-lane mask, store lane shift, load shift and extension
// Revision: 1.0
// ============================================================================
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  i_size,
  input  logic                        i_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]   i_offset,
  input  logic [XLEN-1:0]             i_wdata,
  input  logic [XLEN-1:0]             i_rdata,
  output logic [XLEN/8-1:0]           o_mask,
  output logic [XLEN-1:0]             o_wdata,
  output logic [XLEN-1:0]             o_rdata
);

  localparam int MASK_W = XLEN / 8;
  localparam int OFF_W  = $clog2(MASK_W);

  logic [MASK_W-1:0]      w_base;
  logic [6:0]             w_pad;
  logic [OFF_W+2:0]       w_lane;
  logic [XLEN-1:0]        w_shifted;
  logic [XLEN-1:0]        w_left;
  logic [XLEN-1:0]        w_zext;
  logic signed [XLEN-1:0] w_sext;

  always_comb begin
    case (i_size)
      c_SZ_B: begin
        w_base = MASK_W'(1);
        w_pad  = 7'(XLEN - 8);
      end
      c_SZ_H: begin
        w_base = MASK_W'(3);
        w_pad  = 7'(XLEN - 16);
      end
      c_SZ_W: begin
        w_base = MASK_W'(15);
        w_pad  = 7'(XLEN - 32);
      end
      default: begin
        w_base = '1;
        w_pad  = 7'd0;
      end
    endcase
  end

  assign w_lane  = {i_offset, 3'b000};
  assign o_mask  = w_base << i_offset;
  assign o_wdata = i_wdata << w_lane;

  // Push the loaded field to the top, then shift back down to extend it.
  assign w_shifted = i_rdata >> w_lane;
  assign w_left    = w_shifted << w_pad;
  assign w_zext    = w_left >> w_pad;
  assign w_sext    = $signed(w_left) >>> w_pad;
  assign o_rdata   = i_unsigned ? w_zext : w_sext;

endmodule
`default_nettype wire

// File: rtl/lsu_handshake.sv
`default_nettype none
// ============================================================================
// lsu_handshake : single-outstanding load/store unit with valid/ready memory
// Revision: 1.0
// ============================================================================
module lsu_handshake
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_write,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [XLEN-1:0]     i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  input  logic [4:0]          i_req_rd,
  output logic [XLEN-1:0]     o_mem_addr,
  output logic                o_mem_ren,
  output logic                o_mem_wen,
  output logic [XLEN/8-1:0]   o_mem_mask,
  output logic [XLEN-1:0]     o_mem_wdata,
  input  logic                i_mem_ready,
  input  logic                i_mem_valid,
  input  logic [XLEN-1:0]     i_mem_rdata,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [XLEN-1:0]     o_rsp_rdata,
  output logic [4:0]          o_rsp_rd,
  output logic                o_rsp_trap
);

  localparam int MASK_W = XLEN / 8;
  localparam int OFF_W  = $clog2(MASK_W);

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_trap_q, rsp_trap_d;

  logic              w_req_bad;
  logic              w_issue;
  logic              w_done;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [MASK_W-1:0] w_req_mask;
  logic [XLEN-1:0]   w_req_wdata;
  logic [XLEN-1:0]   w_req_rdata;
  logic [MASK_W-1:0] w_rsp_mask;
  logic [XLEN-1:0]   w_rsp_wdata;
  logic [XLEN-1:0]   w_rsp_rdata;
  logic              w_unused_align;

  assign w_req_bad = lsu_misaligned(i_req_size, i_req_addr[2:0], XLEN == 64);
  assign w_cnt_inc = cnt_q + CNT_W'(1);

  // The counter holds WAIT cycles already spent, so the TIMEOUT-th cycle gives up.
  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  lsu_align #(.XLEN(XLEN)) u_req_align (
    .i_size     (size_q),
    .i_unsigned (unsigned_q),
    .i_offset   (addr_q[OFF_W-1:0]),
    .i_wdata    (wdata_q),
    .i_rdata    ('0),
    .o_mask     (w_req_mask),
    .o_wdata    (w_req_wdata),
    .o_rdata    (w_req_rdata)
  );

  lsu_align #(.XLEN(XLEN)) u_rsp_align (
    .i_size     (size_q),
    .i_unsigned (unsigned_q),
    .i_offset   (addr_q[OFF_W-1:0]),
    .i_wdata    ('0),
    .i_rdata    (i_mem_rdata),
    .o_mask     (w_rsp_mask),
    .o_wdata    (w_rsp_wdata),
    .o_rdata    (w_rsp_rdata)
  );

  assign w_unused_align = &{1'b0, w_req_rdata, w_rsp_mask, w_rsp_wdata};

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_trap_d  = rsp_trap_q;
    case (state_q)
      c_ST_IDLE: begin
        if (i_req_valid) begin
          write_d     = i_req_write;
          size_d      = i_req_size;
          unsigned_d  = i_req_unsigned;
          addr_d      = i_req_addr;
          wdata_d     = i_req_wdata;
          rd_d        = i_req_rd;
          rsp_rdata_d = '0;
          rsp_trap_d  = w_req_bad;
          state_d     = w_req_bad ? c_ST_DONE : c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        if (i_mem_ready) begin
          cnt_d   = '0;
          state_d = write_q ? c_ST_DONE : c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        cnt_d = w_cnt_inc;
        if (i_mem_valid) begin
          rsp_rdata_d = w_rsp_rdata;
          state_d     = c_ST_DONE;
        end else if (w_timeout) begin
          rsp_trap_d  = 1'b1;
          rsp_rdata_d = '0;
          state_d     = c_ST_DONE;
        end
      end
      default: begin
        if (i_rsp_ready) begin
          state_d = c_ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= c_ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 5'd0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_trap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_trap_q  <= rsp_trap_d;
    end
  end

  assign w_issue = (state_q == c_ST_ISSUE);
  assign w_done  = (state_q == c_ST_DONE);

  assign o_req_ready = (state_q == c_ST_IDLE);
  assign o_mem_ren   = w_issue & ~write_q;
  assign o_mem_wen   = w_issue & write_q;
  assign o_mem_addr  = w_issue ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign o_mem_mask  = w_issue ? w_req_mask : '0;
  assign o_mem_wdata = (w_issue & write_q) ? w_req_wdata : '0;
  assign o_rsp_valid = w_done;
  assign o_rsp_rdata = w_done ? rsp_rdata_q : '0;
  assign o_rsp_rd    = (w_done & ~write_q) ? rd_q : 5'd0;
  assign o_rsp_trap  = w_done & rsp_trap_q;

endmodule
`default_nettype wire
